// File: rtl/hqm_reorder_pipe_if_prot_rx_if.sv
// Enqueue-link bundle between a ROP producer, the rx protection block and its consumer.
// master = environment side driving in_* and out_ready; slave = the rx protection block.
interface hqm_reorder_pipe_if_prot_rx_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              in_v;
  logic [DWIDTH-1:0] in_data;
  logic              in_par;
  logic              in_ready;
  logic              out_v;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_v, in_data, in_par, out_ready,
    input  in_ready, out_v, out_data
  );

  modport slave (
    input  in_v, in_data, in_par, out_ready,
    output in_ready, out_v, out_data
  );
endinterface

// File: rtl/hqm_reorder_pipe_if_prot_rx.sv
// Receive-side protection for a reorder-pipe enqueue link: small FIFO in RUN,
// sink-and-count in DRAIN while flr_prep is active, quiesced once the link has gone idle.
module hqm_reorder_pipe_if_prot_rx #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned QUIET_CYC = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flr_prep,
  hqm_reorder_pipe_if_prot_rx_if.slave pipe,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     quiesced,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     par_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned QW = $clog2(QUIET_CYC + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [QW-1:0]     quiet_cnt;
  logic              accept, pop, par_bad, enq;

  assign accept   = pipe.in_v & pipe.in_ready;
  assign pop      = pipe.out_v & pipe.out_ready;
  assign par_bad  = ^{pipe.in_data, pipe.in_par};
  // The RUN->DRAIN cycle still accepts, but that beat is discarded rather than enqueued.
  assign enq      = (state == RUN) & ~flr_prep & accept;
  assign fifo_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:   if (flr_prep)              state_nxt = DRAIN;
      DRAIN: if (!flr_prep && quiesced) state_nxt = RUN;
    endcase
  end

  always_comb begin
    pipe.in_ready = 1'b1;
    pipe.out_v    = 1'b0;
    pipe.out_data = '0;
    quiesced      = 1'b0;
    unique case (state)
      RUN: begin
        pipe.in_ready = (cnt < CW'(DEPTH));
        pipe.out_v    = (cnt != '0);
        if (cnt != '0) pipe.out_data = mem[rd_ptr];
      end
      DRAIN: quiesced = (quiet_cnt == QW'(QUIET_CYC));
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= pipe.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      quiet_cnt <= '0;
      drop_cnt  <= '0;
      par_err   <= 1'b0;
    end else begin
      par_err <= 1'b0;
      unique case (state)
        RUN: begin
          if (flr_prep) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            quiet_cnt <= '0;
            drop_cnt  <= CNT_W'(accept);
          end else begin
            par_err <= accept & par_bad;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      cnt <= cnt + 1'b1;
            else if (!accept && pop) cnt <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (accept && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          if (pipe.in_v)                          quiet_cnt <= '0;
          else if (quiet_cnt != QW'(QUIET_CYC))   quiet_cnt <= quiet_cnt + 1'b1;
          if (state_nxt == RUN)                   quiet_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hqm_reorder_pipe_if_prot_rx.sv
// Bench for hqm_reorder_pipe_if_prot_rx: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_hqm_reorder_pipe_if_prot_rx;

  localparam int unsigned DWIDTH    = 32;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned QUIET_CYC = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned DROP_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flr_prep;
  logic [CW-1:0]     fifo_cnt;
  logic              quiesced;
  logic [CNT_W-1:0]  drop_cnt;
  logic              par_err;

  hqm_reorder_pipe_if_prot_rx_if #(.DWIDTH(DWIDTH)) pipe ();

  hqm_reorder_pipe_if_prot_rx #(
    .DWIDTH    (DWIDTH),
    .DEPTH     (DEPTH),
    .QUIET_CYC (QUIET_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flr_prep (flr_prep),
    .pipe     (pipe),
    .fifo_cnt (fifo_cnt),
    .quiesced (quiesced),
    .drop_cnt (drop_cnt),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of buffered beats plus drain bookkeeping.
  logic [DWIDTH-1:0] mq[$];
  bit                m_drain;
  int unsigned       m_drop, m_quiet;
  bit                m_perr;

  task automatic model_reset();
    mq.delete();
    m_drain = 0;
    m_drop  = 0;
    m_quiet = 0;
    m_perr  = 0;
  endtask

  task automatic check_outputs();
    bit                ov;
    logic [DWIDTH-1:0] od;
    ov = !m_drain && mq.size() != 0;
    od = '0;
    if (ov) od = mq[0];
    check("in_ready", pipe.in_ready, m_drain || mq.size() < DEPTH);
    check("out_v",    pipe.out_v, ov);
    check("out_data", pipe.out_data, od);
    check("fifo_cnt", fifo_cnt, mq.size());
    check("quiesced", quiesced, m_drain && m_quiet == QUIET_CYC);
    check("drop_cnt", drop_cnt, m_drop);
    check("par_err",  par_err, m_perr);
  endtask

  task automatic cycle(input bit v, input logic [DWIDTH-1:0] d, input bit par_ok,
                       input bit ordy, input bit flr, output bit acc);
    bit rdy, ov, q;
    @(negedge clk);
    pipe.in_v      = v;
    pipe.in_data   = d;
    pipe.in_par    = par_ok ? ^d : ~^d;
    pipe.out_ready = ordy;
    flr_prep       = flr;
    #1;
    check_outputs();
    rdy = m_drain || mq.size() < DEPTH;
    ov  = !m_drain && mq.size() != 0;
    q   = m_drain && m_quiet == QUIET_CYC;
    acc = v && rdy;
    if (!m_drain) begin
      if (flr) begin
        m_drain = 1;
        mq.delete();
        m_drop  = acc ? 1 : 0;
        m_quiet = 0;
        m_perr  = 0;
      end else begin
        m_perr = acc && !par_ok;
        if (ov && ordy) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end else begin
      m_perr = 0;
      if (acc && m_drop < DROP_MAX) m_drop++;
      if (v) m_quiet = 0;
      else if (m_quiet < QUIET_CYC) m_quiet++;
      if (!flr && q) begin
        m_drain = 0;
        m_quiet = 0;
      end
    end
  endtask

  // Asynchronous reset raised between edges, outputs checked before any clock.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_in_ready", pipe.in_ready, 1'b1);
    check("rst_out_v", pipe.out_v, 1'b0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check_outputs();
    @(negedge clk);
    pipe.in_v = 1'b0;
    flr_prep  = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    bit                acc;
    bit                pend, pok, flr;
    logic [DWIDTH-1:0] pd;

    rst = 1'b1;
    flr_prep = 1'b0;
    pipe.in_v = 1'b0;
    pipe.in_data = '0;
    pipe.in_par = 1'b0;
    pipe.out_ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Fill with A,B while stalled, then drain in order.
    cycle(1, 32'hAAAA_0001, 1, 0, 0, acc);
    cycle(1, 32'hBBBB_0002, 1, 0, 0, acc);
    cycle(0, '0, 1, 0, 0, acc);
    check("full_in_ready", pipe.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 1, 0, acc);

    // Streaming at one beat per cycle.
    for (int i = 0; i < 8; i++) cycle(1, 32'h100 + i, 1, 1, 0, acc);
    for (int i = 0; i < 2; i++) cycle(0, '0, 1, 1, 0, acc);

    // Parity error on 0x1 with par=0; beat still delivered.
    cycle(1, 32'h1, 0, 1, 0, acc);
    for (int i = 0; i < 2; i++) cycle(0, '0, 1, 1, 0, acc);

    // Flush a full FIFO, drop 3 beats, go quiet, wake, leave early, return to RUN.
    cycle(1, 32'hC0, 1, 0, 0, acc);
    cycle(1, 32'hD0, 1, 0, 0, acc);
    cycle(0, '0, 1, 0, 1, acc);
    for (int i = 0; i < 3; i++) cycle(1, 32'hE0 + i, 1, 1, 1, acc);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 1, 1, acc);
    cycle(1, 32'hF0, 1, 1, 1, acc);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1, 0, acc);
    for (int i = 0; i < 4; i++) cycle(1, 32'h200 + i, 1, 1, 0, acc);
    cycle(0, '0, 1, 1, 0, acc);

    // drop_cnt saturation.
    for (int i = 0; i < DROP_MAX + 4; i++) cycle(1, $urandom, 1, 1, 1, acc);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1, 0, acc);

    // Reset with one beat buffered.
    cycle(1, 32'h5A5A, 1, 0, 0, acc);
    cycle(0, '0, 1, 0, 0, acc);
    apply_reset();

    // Random traffic with FLR episodes and occasional resets.
    pend = 0; pok = 1; flr = 0; pd = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!pend) begin
        pend = ($urandom % 100) < (flr ? 35 : 65);
        pd   = $urandom;
        pok  = ($urandom % 8) != 0;
      end
      if ($urandom % 40 == 0) flr = !flr;
      cycle(pend, pd, pok, ($urandom % 4) != 0, flr, acc);
      if (acc) pend = 0;
      if ($urandom % 700 == 0) begin
        apply_reset();
        pend = 0;
        flr  = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
